// File: rtl/mux_rr_n_para_1.sv
// N-channel registered mux with valid/ready handshakes, fixed-select or round-robin grant.
// Optional 16-bit output transfer counter enabled by defining MUX_RR_CONT_EN.
module mux_rr_n_para_1 #(
  parameter int WIDTH    = 4,
  parameter int N_CANAIS = 4,
  localparam int SEL_W   = $clog2(N_CANAIS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CANAIS*WIDTH-1:0] D,
  input  logic [N_CANAIS-1:0]       D_valid,
  output logic [N_CANAIS-1:0]       D_ready,
  input  logic                      modo,
  input  logic [SEL_W-1:0]          S,
  output logic [WIDTH-1:0]          Y,
  output logic                      Y_valid,
  input  logic                      Y_ready,
  output logic [SEL_W-1:0]          Y_canal
`ifdef MUX_RR_CONT_EN
  ,
  output logic [15:0]               cont_transf
`endif
);

  logic [WIDTH-1:0] y_r;
  logic             y_valid_r;
  logic [SEL_W-1:0] y_canal_r;
  logic [SEL_W-1:0] ptr_r;

  logic             aceita_s;
  logic             found_s;
  logic             xfer_s;
  logic [SEL_W-1:0] g_s;
  logic [WIDTH-1:0] y_next_s;
  int               idx_s;

  assign aceita_s = !y_valid_r | Y_ready;
  assign xfer_s   = found_s & aceita_s;
  assign y_next_s = D[g_s*WIDTH +: WIDTH];

  // Grant selection: fixed by S, or first valid channel scanning upward from ptr_r.
  always_comb begin
    found_s = 1'b0;
    g_s     = '0;
    idx_s   = 0;
    if (modo) begin
      for (int k = 0; k < N_CANAIS; k++) begin
        idx_s = ((int'(ptr_r) + k) >= N_CANAIS) ? (int'(ptr_r) + k - N_CANAIS)
                                                : (int'(ptr_r) + k);
        if (!found_s && D_valid[idx_s]) begin
          found_s = 1'b1;
          g_s     = SEL_W'(idx_s);
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      if (int'(S) < N_CANAIS) begin
        found_s = D_valid[S];
        g_s     = S;
      end else begin
        found_s = 1'b0;
        g_s     = '0;
      end
    end
  end

  // One-hot ready toward the granted channel, only when the output slot can take a word.
  always_comb begin
    D_ready = '0;
    if (xfer_s) begin
      D_ready[g_s] = 1'b1;
    end else begin
      D_ready = '0;
    end
  end

  // Output register stage and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r       <= '0;
      y_valid_r <= 1'b0;
      y_canal_r <= '0;
      ptr_r     <= '0;
    end else begin
      if (xfer_s) begin
        y_r       <= y_next_s;
        y_canal_r <= g_s;
        y_valid_r <= 1'b1;
        if (modo) begin
          ptr_r <= (g_s == SEL_W'(N_CANAIS - 1)) ? '0 : g_s + SEL_W'(1);
        end else begin
          ptr_r <= ptr_r;
        end
      end else if (Y_ready) begin
        y_valid_r <= 1'b0;
      end else begin
        y_valid_r <= y_valid_r;
      end
    end
  end

  assign Y       = y_r;
  assign Y_valid = y_valid_r;
  assign Y_canal = y_canal_r;

`ifdef MUX_RR_CONT_EN
  logic [15:0] cont_r;

  // Counts completed output handshakes; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont_r <= 16'd0;
    end else if (y_valid_r && Y_ready) begin
      cont_r <= cont_r + 16'd1;
    end else begin
      cont_r <= cont_r;
    end
  end

  assign cont_transf = cont_r;
`endif

endmodule

// File: tb/tb_mux_rr_n_para_1.sv
// Directed self-checking bench for mux_rr_n_para_1 (N_CANAIS=4, WIDTH=4).
// Counter checks compile in only when MUX_RR_CONT_EN is defined.
module tb_mux_rr_n_para_1;

  logic        clk;
  logic        rst_n;
  logic [15:0] D;
  logic [3:0]  D_valid;
  logic [3:0]  D_ready;
  logic        modo;
  logic [1:0]  S;
  logic [3:0]  Y;
  logic        Y_valid;
  logic        Y_ready;
  logic [1:0]  Y_canal;
`ifdef MUX_RR_CONT_EN
  logic [15:0] cont_transf;
`endif

  int total;
  int bad;

  mux_rr_n_para_1 #(.WIDTH(4), .N_CANAIS(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .D       (D),
    .D_valid (D_valid),
    .D_ready (D_ready),
    .modo    (modo),
    .S       (S),
    .Y       (Y),
    .Y_valid (Y_valid),
    .Y_ready (Y_ready),
    .Y_canal (Y_canal)
`ifdef MUX_RR_CONT_EN
    ,
    .cont_transf (cont_transf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    D       = 16'h0000;
    D_valid = 4'h0;
    modo    = 1'b0;
    S       = 2'd0;
    Y_ready = 1'b0;

    // Reset held with inputs toggling
    for (int i = 0; i < 4; i++) begin
      D       = 16'($urandom);
      D_valid = 4'hF;
      Y_ready = i[0];
      modo    = i[1];
      S       = 2'(i);
      tick();
      chk("rst_y",       32'(Y),       32'h0);
      chk("rst_y_valid", 32'(Y_valid), 32'h0);
      chk("rst_y_canal", 32'(Y_canal), 32'h0);
    end
    D_valid = 4'h0;
    modo    = 1'b0;
    S       = 2'd0;
    Y_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_d_ready", 32'(D_ready), 32'h0);
    tick();
    chk("post_rst_y_valid", 32'(Y_valid), 32'h0);

    // Fixed mode, S=2
    D       = {4'h3, 4'hA, 4'h1, 4'h2};
    D_valid = 4'hF;
    S       = 2'd2;
    #1;
    chk("fix_d_ready", 32'(D_ready), 32'h4);
    tick();
    chk("fix_y",       32'(Y),       32'hA);
    chk("fix_y_canal", 32'(Y_canal), 32'h2);
    chk("fix_y_valid", 32'(Y_valid), 32'h1);
    D_valid = 4'b1011;
    #1;
    chk("fix_novalid_d_ready", 32'(D_ready), 32'h0);
    tick();
    chk("fix_novalid_y_valid", 32'(Y_valid), 32'h0);
    chk("fix_novalid_y_hold",  32'(Y),       32'hA);

    // Round-robin, all valid, Dk = k+5
    modo    = 1'b1;
    D       = 16'h8765;
    D_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_d_ready", 32'(D_ready), 32'(1 << (k % 4)));
      tick();
      chk("rr_y_canal", 32'(Y_canal), 32'(k % 4));
      chk("rr_y",       32'(Y),       32'(5 + (k % 4)));
      chk("rr_y_valid", 32'(Y_valid), 32'h1);
    end

    // Backpressure: word 5 from channel 0 must hold
    Y_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_d_ready", 32'(D_ready), 32'h0);
      tick();
      chk("bp_y",       32'(Y),       32'h5);
      chk("bp_y_canal", 32'(Y_canal), 32'h0);
      chk("bp_y_valid", 32'(Y_valid), 32'h1);
    end
    Y_ready = 1'b1;
    #1;
    chk("bp_release_d_ready", 32'(D_ready), 32'h2);
    tick();
    chk("bp_release_y",       32'(Y),       32'h6);
    chk("bp_release_y_canal", 32'(Y_canal), 32'h1);
    chk("bp_release_y_valid", 32'(Y_valid), 32'h1);

    // Sparse round-robin: grant 2 first (ptr -> 3), then only channel 1
    #1;
    chk("sp_g2_d_ready", 32'(D_ready), 32'h4);
    tick();
    chk("sp_g2_y_canal", 32'(Y_canal), 32'h2);
    D_valid = 4'b0010;
    #1;
    chk("sp_g1_d_ready", 32'(D_ready), 32'h2);
    tick();
    chk("sp_g1_y_canal", 32'(Y_canal), 32'h1);
    chk("sp_g1_y",       32'(Y),       32'h6);
    modo    = 1'b0;
    S       = 2'd3;
    D_valid = 4'b1000;
    #1;
    chk("sp_fix3_d_ready", 32'(D_ready), 32'h8);
    tick();
    chk("sp_fix3_y_canal", 32'(Y_canal), 32'h3);
    chk("sp_fix3_y",       32'(Y),       32'h8);
    modo    = 1'b1;
    D_valid = 4'hF;
    #1;
    chk("sp_ptr_kept_d_ready", 32'(D_ready), 32'h4);
    tick();
    chk("sp_ptr_kept_y_canal", 32'(Y_canal), 32'h2);

    // Reset mid-transfer with backpressure discards the word at once
    Y_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_y_valid", 32'(Y_valid), 32'h0);
    chk("midrst_y",       32'(Y),       32'h0);
    chk("midrst_y_canal", 32'(Y_canal), 32'h0);
    tick();
    rst_n = 1'b1;

`ifdef MUX_RR_CONT_EN
    // Counter wrap: first edge only loads Y, the next 65537 edges each complete a transfer
    chk("cnt_reset", 32'(cont_transf), 32'h0);
    Y_ready = 1'b1;
    modo    = 1'b1;
    D_valid = 4'hF;
    for (int k = 0; k < 65538; k++) begin
      tick();
    end
    chk("cnt_wrap", 32'(cont_transf), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("cnt_midrst",         32'(cont_transf), 32'h0);
    chk("cnt_midrst_y_valid", 32'(Y_valid),     32'h0);
    tick();
    rst_n = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
